// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame-length limits, parity helper.
// Pure definitions, no logic; used by the receiver and the transmitter.
package uart_pkg;

  localparam int UART_MIN_LEN = 5;
  localparam int UART_MAX_LEN = 8;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t IDLE      = 3'd0;
  localparam rx_state_t START     = 3'd1;
  localparam rx_state_t DATA      = 3'd2;
  localparam rx_state_t PARITY    = 3'd3;
  localparam rx_state_t STOP1     = 3'd4;
  localparam rx_state_t STOP2     = 3'd5;
  localparam rx_state_t DONE      = 3'd6;
  localparam rx_state_t WAIT_IDLE = 3'd7;

  // Out-of-range lengths fall back to a full byte.
  function automatic logic [3:0] uart_len(input logic [3:0] length);
    if (int'(length) < UART_MIN_LEN || int'(length) > UART_MAX_LEN)
      return 4'(UART_MAX_LEN);
    return length;
  endfunction

  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic [3:0] length,
                                       input logic       parity_type);
    logic [7:0] masked;
    masked = '0;
    for (int i = 0; i < UART_MAX_LEN; i++)
      if (i < int'(length)) masked[i] = data[i];
    return parity_type ? ^masked : ~^masked;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF synchronizer for the serial line plus falling-edge detect; flops reset to idle-high.
// Latency 2 cycles to rxs, fall is combinational on the synchronized value; no backpressure.
module uart_rx_sync (
  input  logic rx_clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxs  = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// rx_done ~3 cycles after the last stop-bit mid-point; no backpressure, frames are never stalled.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] length,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop2,
  output logic [7:0] rx_out,
  output logic       rx_done,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_err
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(OVERSAMPLE - 1);

  logic          rxs;
  logic          fall;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [3:0]    lat_len;
  logic          lat_par_en;
  logic          lat_par_type;
  logic          lat_stop2;
  logic          par_err;
  logic          frm_err;
  logic          bit_end;

  uart_rx_sync u_sync (
    .rx_clk (rx_clk),
    .rst    (rst),
    .rx     (rx),
    .rxs    (rxs),
    .fall   (fall)
  );

  assign bit_end = (cnt == BIT_M1);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      lat_len       <= 4'(UART_MAX_LEN);
      lat_par_en    <= 1'b0;
      lat_par_type  <= 1'b0;
      lat_stop2     <= 1'b0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      rx_out        <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            if (!rxs) begin
              lat_len      <= uart_len(length);
              lat_par_en   <= parity_en;
              lat_par_type <= parity_type;
              lat_stop2    <= stop2;
              shreg        <= '0;
              bit_idx      <= '0;
              par_err      <= 1'b0;
              frm_err      <= 1'b0;
              state        <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            if ({1'b0, bit_idx} == lat_len - 4'd1)
              state <= lat_par_en ? PARITY : STOP1;
            else
              bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_err <= (rxs != uart_parity(shreg, lat_len, lat_par_type));
            state   <= STOP1;
          end
        end
        STOP1: begin
          if (bit_end) begin
            cnt <= '0;
            if (lat_stop2) begin
              frm_err <= frm_err | ~rxs;
              state   <= STOP2;
            end else begin
              rx_out        <= shreg;
              rx_parity_err <= par_err;
              rx_frame_err  <= frm_err | ~rxs;
              state         <= DONE;
            end
          end
        end
        STOP2: begin
          if (bit_end) begin
            cnt           <= '0;
            rx_out        <= shreg;
            rx_parity_err <= par_err;
            rx_frame_err  <= frm_err | ~rxs;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= rxs ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_done = (state == DONE);
  assign rx_err  = rx_parity_err | rx_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames driven by a behavioural serial transmitter; each completed
// frame is compared against the expected byte, error flags and rx_done arrival window.
module tb_uart_rx;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic        e;
    logic [31:0] t;
  } obs_t;

  logic       rx_clk;
  logic       rst;
  logic       rx;
  logic [3:0] length;
  logic       parity_en;
  logic       parity_type;
  logic       stop2;
  logic [7:0] rx_out;
  logic       rx_done;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   stray = 0;
  obs_t obs_q[$];
  logic [10:0] prev_outs = '0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .rx_clk        (rx_clk),
    .rst           (rst),
    .rx            (rx),
    .length        (length),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .stop2         (stop2),
    .rx_out        (rx_out),
    .rx_done       (rx_done),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_err        (rx_err)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  always @(posedge rx_clk) cyc <= cyc + 1;

  // Record every completed frame; outputs must not move outside an rx_done cycle.
  always @(negedge rx_clk) begin
    logic [10:0] cur;
    cur = {rx_out, rx_parity_err, rx_frame_err, rx_err};
    if (rx_done === 1'b1)
      obs_q.push_back({rx_out, rx_parity_err, rx_frame_err, rx_err, 32'(cyc)});
    if (rst !== 1'b1 && rx_done !== 1'b1 && cur !== prev_outs)
      stray++;
    prev_outs = cur;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    rx = b;
    tick(OS);
  endtask

  // Behavioural transmitter plus expectation for one frame.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] len, input logic pen,
                            input logic ptype, input logic st2, input logic pflip,
                            input logic s2val, output obs_t e);
    int         el;
    int         nb;
    int         ones;
    logic [7:0] md;
    logic       pbit;
    length      = len;
    parity_en   = pen;
    parity_type = ptype;
    stop2       = st2;
    el   = (len >= 5 && len <= 8) ? int'(len) : 8;
    md   = d & 8'((1 << el) - 1);
    ones = $countones(md);
    pbit = ptype ? (ones % 2 == 1) : (ones % 2 == 0);
    pbit = pbit ^ pflip;
    nb   = 1 + el + int'(pen) + 1 + int'(st2);
    e.d  = md;
    e.pe = pen & pflip;
    e.fe = st2 & ~s2val;
    e.e  = e.pe | e.fe;
    e.t  = 32'(cyc + OS / 2 + 3 + OS * (nb - 1));
    put_bit(1'b0);
    length      = 4'($urandom);
    parity_en   = 1'($urandom);
    parity_type = 1'($urandom);
    stop2       = 1'($urandom);
    for (int i = 0; i < el; i++) put_bit(md[i]);
    if (pen) put_bit(pbit);
    put_bit(1'b1);
    if (st2) put_bit(s2val);
    rx = 1'b1;
  endtask

  task automatic check_frame(input string tag, input obs_t e);
    obs_t o;
    chk({tag, ".cnt"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, ".data"}, 32'(o.d), 32'(e.d));
      chk({tag, ".perr"}, 32'(o.pe), 32'(e.pe));
      chk({tag, ".ferr"}, 32'(o.fe), 32'(e.fe));
      chk({tag, ".err"}, 32'(o.e), 32'(e.e));
      total++;
      assert (o.t + 1 >= e.t && o.t <= e.t + 1)
      else begin
        bad++;
        $error("FAIL %s.lat observed=%0d expected=%0d+-1", tag, o.t, e.t);
      end
    end
    obs_q.delete();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".out"}, 32'(rx_out), 32'd0);
    chk({tag, ".done"}, 32'(rx_done), 32'd0);
    chk({tag, ".perr"}, 32'(rx_parity_err), 32'd0);
    chk({tag, ".ferr"}, 32'(rx_frame_err), 32'd0);
    chk({tag, ".err"}, 32'(rx_err), 32'd0);
  endtask

  initial begin
    obs_t       e;
    int         t0;
    int         gap;
    logic [7:0] rd;
    logic [3:0] rl;
    logic       rpen, rpt, rs2, rpf, rs2v;

    rst         = 1'b1;
    rx          = 1'b1;
    length      = 4'd8;
    parity_en   = 1'b0;
    parity_type = 1'b0;
    stop2       = 1'b0;
    tick(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    tick(5);

    send_frame(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e);
    check_frame("a5_par", e);
    tick(OS);

    send_frame(8'h13, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e);
    check_frame("13_stop2", e);
    tick(OS);

    send_frame(8'h13, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e);
    check_frame("13_badstop2", e);
    tick(OS);

    // Reset in the middle of the data bits of 0x55.
    length    = 4'd8;
    parity_en = 1'b0;
    stop2     = 1'b0;
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    tick(5);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    chk_outs_zero("midrst");
    rst = 1'b0;
    tick(3 * OS);
    chk("midrst.nodone", 32'(obs_q.size()), 32'd0);
    obs_q.delete();

    send_frame(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    check_frame("81_after_rst", e);
    tick(OS);

    send_frame(8'h0F, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, e);
    check_frame("0f_badpar", e);
    tick(OS);

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2 * OS);
    chk("glitch.nodone", 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    check_frame("3c_after_glitch", e);
    tick(OS);

    // Break: line low for 20 bit times.
    length    = 4'd8;
    parity_en = 1'b0;
    stop2     = 1'b0;
    t0        = cyc;
    rx        = 1'b0;
    tick(20 * OS);
    e.d  = 8'h00;
    e.pe = 1'b0;
    e.fe = 1'b1;
    e.e  = 1'b1;
    e.t  = 32'(t0 + OS / 2 + 3 + OS * 9);
    check_frame("break", e);
    tick(4 * OS);
    chk("break.hold", 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    rx = 1'b1;
    tick(OS);

    for (int n = 0; n < 40; n++) begin
      rd   = 8'($urandom);
      rl   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(5, 8));
      rpen = 1'($urandom);
      rpt  = 1'($urandom);
      rs2  = 1'($urandom);
      rpf  = rpen && ($urandom_range(0, 3) == 0);
      rs2v = !(rs2 && ($urandom_range(0, 5) == 0));
      send_frame(rd, rl, rpen, rpt, rs2, rpf, rs2v, e);
      check_frame($sformatf("rnd%0d", n), e);
      if (!rs2v) gap = OS;
      else gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3 * OS));
      tick(gap);
    end

    tick(2 * OS);
    chk("no_extra_done", 32'(obs_q.size()), 32'd0);
    chk("outs_stable_between_frames", 32'(stray), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the downstream stage of `uart_tx` on the serial line. It recovers frames of 5–8 data bits (LSB first), with optional parity and one or two stop bits, from the asynchronous `rx` input. Each frame is presented as a parallel byte with a one-cycle `rx_done` strobe and error flags. Frame-format inputs are identical in meaning to the transmitter's, so a `tx`→`rx` loopback with shared settings is lossless.

## Interface
- `OVERSAMPLE`, 16: `rx_clk` cycles per bit period; even, ≥4.
- `rx_clk  input  1  receiver clock, OVERSAMPLE × bit rate`
- `rst  input  1  asynchronous, active-high reset`
- `rx  input  1  serial line, idle high, asynchronous to rx_clk`
- `length  input  4  data bits per frame, 5..8; any other value treated as 8`
- `parity_en  input  1  parity bit present after data`
- `parity_type  input  1  expected parity = parity_type ? ^data : ~^data (over `length` bits)`
- `stop2  input  1  two stop bits expected`
- `rx_out  output  8  received data, right-aligned, upper unused bits 0`
- `rx_done  output  1  one-cycle strobe, frame complete`
- `rx_parity_err  output  1  parity mismatch, valid with rx_done`
- `rx_frame_err  output  1  a stop bit sampled low, valid with rx_done`
- `rx_err  output  1  rx_parity_err | rx_frame_err`

## Operation
- `rx` passes through a 2-FF synchronizer. All decisions use the synchronized value `rxs`.
- States:
  - IDLE: wait for `rxs` falling edge, then clear the sample counter and go to START.
  - START: after OVERSAMPLE/2 cycles (mid-bit), sample `rxs`. If 0, latch `length`/`parity_en`/`parity_type`/`stop2` and go to DATA. If 1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: every OVERSAMPLE cycles, sample into bit index 0..len-1. After the last bit, go to PARITY if parity is enabled, else STOP1.
  - PARITY: sample one bit and compare it with the expected parity computed over the latched data.
  - STOP1: sample; a 0 sets frame error. Go to STOP2 if `stop2` was latched, else DONE.
  - STOP2: sample; a 0 sets frame error. Go to DONE.
  - DONE: for one cycle, assert `rx_done`, load `rx_out`, and set the error flags. Go to IDLE if `rxs`=1, else WAIT_IDLE.
  - WAIT_IDLE (break or low line after a framing error): stay until `rxs`=1, then go to IDLE. No new frame can start until the line returns high.
- Frame-format inputs are ignored after the latch point. Changing them mid-frame does not affect the current frame.
- `rx_out` and the error flags hold their values until the next DONE.

## Timing
- Reset (asynchronous): state IDLE, counters 0, synchronizer flops 1, `rx_out`=0, `rx_done`=0, all error flags 0. A reset mid-frame discards the frame with no `rx_done`.
- Sample point = falling-edge detect + OVERSAMPLE/2 + k·OVERSAMPLE cycles, for k = 0 (start), 1..len (data), then parity and stop bits.
- `rx_done` rises on the cycle after the last stop-bit sample. The end-to-end latency from the true mid-point of the last stop bit is about 3 cycles (2 synchronizer + 1).
- Back-to-back frames: a falling edge in the cycle right after DONE is accepted. There is no dead time beyond the DONE cycle.
- The error flags and `rx_out` change only in the cycle where `rx_done`=1.

## Structure
- `uart_pkg`: `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, WAIT_IDLE), `UART_MIN_LEN`=5, `UART_MAX_LEN`=8, and a parity function (data, length, type). `uart_tx` shares these.
- Sub-module `uart_rx_sync`: 2-FF synchronizer plus falling-edge detector, with reset value 1.

## Test plan
- OVERSAMPLE=16, length=8, parity_en=1, parity_type=0, stop2=0, send 0xA5 with parity bit 1 → `rx_out`=0xA5, one `rx_done` pulse, all error flags 0.
- length=5, parity_en=0, stop2=1, send 0x13 → `rx_out`=0x13, `rx_done` after the second stop bit, no errors. A repeat with the second stop bit at 0 → `rx_frame_err`=1, `rx_err`=1.
- length=8, parity_en=1, parity_type=1, send 0x0F with the parity bit inverted (1) → `rx_out`=0x0F, `rx_parity_err`=1, `rx_frame_err`=0.
- Low pulse on `rx` lasting 4 cycles → no `rx_done`, state back in IDLE, and an immediately following valid 0x3C frame is received correctly.
- Hold `rx` low for 20 bit times (break) → one `rx_done` with `rx_out`=0x00 and `rx_frame_err`=1, then no further frames until `rx` returns high.
- Assert `rst` mid-data of frame 0x55 → all outputs 0 with no `rx_done`. After release, a 0x81 frame → `rx_out`=0x81. Loopback from `uart_tx` with random data and formats → every byte matches.
